// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe: three-stage pipelined split-recursive multiplier with a
// per-transaction choice between exact and lower-part-OR (LOA) summation.
// Operands are split at SPLIT into high/low halves; four partial products are
// combined through two adders that OR their low APPROX_BITS bits when
// approximate mode is selected.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid/in_ready       input handshake (in_ready is combinational)
//   in_a, in_b              operands (WIDTH bits)
//   in_mode                 0 = exact, 1 = approximate
//   in_tag                  sideband tag carried with the product
//   out_valid/out_ready     output handshake
//   out_p                   product (2*WIDTH bits)
//   out_tag, out_mode       tag and mode of the product
//   occupancy               number of occupied pipeline stages (0..3)
module approx_mult_pipe #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SPLIT       = 6,
  parameter int unsigned APPROX_BITS = 4,
  parameter int unsigned TAG_W       = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_mode,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_mode,
  output logic [1:0]           occupancy
);

  localparam int unsigned H   = WIDTH - SPLIT;
  localparam int unsigned XW  = WIDTH + 1;
  localparam int unsigned OPW = 2*WIDTH - SPLIT;

  // Stage 1 registers
  logic                 s1_v;
  logic [2*H-1:0]       s1_p1;
  logic [WIDTH-1:0]     s1_p2;
  logic [WIDTH-1:0]     s1_p3;
  logic [2*SPLIT-1:0]   s1_p4;
  logic                 s1_mode;
  logic [TAG_W-1:0]     s1_tag;

  // Stage 2 registers
  logic                 s2_v;
  logic [XW-1:0]        s2_x;
  logic [OPW-1:0]       s2_op1;
  logic [SPLIT-1:0]     s2_lo;
  logic                 s2_mode;
  logic [TAG_W-1:0]     s2_tag;

  // Handshake: a stage moves forward when its successor is empty or moving
  logic s2_adv_c;
  logic s1_adv_c;
  assign s2_adv_c = !out_valid || out_ready;
  assign s1_adv_c = !s2_v || s2_adv_c;
  assign in_ready = !s1_v || s1_adv_c;

  logic s1_v_n, s2_v_n, s3_v_n;
  assign s1_v_n = in_ready ? in_valid : s1_v;
  assign s2_v_n = s1_adv_c ? s1_v : s2_v;
  assign s3_v_n = s2_adv_c ? s2_v : out_valid;

  // Partial products from the operand halves
  logic [H-1:0]       ah_c, bh_c;
  logic [SPLIT-1:0]   al_c, bl_c;
  logic [2*H-1:0]     p1_c;
  logic [WIDTH-1:0]   p2_c, p3_c;
  logic [2*SPLIT-1:0] p4_c;
  assign ah_c = in_a[WIDTH-1:SPLIT];
  assign al_c = in_a[SPLIT-1:0];
  assign bh_c = in_b[WIDTH-1:SPLIT];
  assign bl_c = in_b[SPLIT-1:0];
  assign p1_c = (2*H)'(ah_c) * (2*H)'(bh_c);
  assign p2_c = WIDTH'(ah_c) * WIDTH'(bl_c);
  assign p3_c = WIDTH'(al_c) * WIDTH'(bh_c);
  assign p4_c = (2*SPLIT)'(al_c) * (2*SPLIT)'(bl_c);

  // Exact sums for both adders
  logic [XW-1:0]  x_exact_c, x_loa_c, x_c;
  logic [OPW-1:0] x_ext_c, f_exact_c, f_loa_c, f_c;
  assign x_exact_c = XW'(s1_p2) + XW'(s1_p3);
  assign x_ext_c   = OPW'(s2_x);
  assign f_exact_c = s2_op1 + x_ext_c;

  // LOA variants: OR the low bits, carry in from the AND of their top bits
  if (APPROX_BITS > 0) begin : g_loa
    localparam int unsigned K = APPROX_BITS;
    assign x_loa_c = {(XW-K)'(XW'(s1_p2[WIDTH-1:K]) + XW'(s1_p3[WIDTH-1:K])
                              + XW'(s1_p2[K-1] & s1_p3[K-1])),
                      s1_p2[K-1:0] | s1_p3[K-1:0]};
    assign f_loa_c = {(OPW-K)'(s2_op1[OPW-1:K] + x_ext_c[OPW-1:K]
                               + (OPW-K)'(s2_op1[K-1] & x_ext_c[K-1])),
                      s2_op1[K-1:0] | x_ext_c[K-1:0]};
  end else begin : g_exact
    assign x_loa_c = x_exact_c;
    assign f_loa_c = f_exact_c;
  end

  assign x_c = s1_mode ? x_loa_c : x_exact_c;
  assign f_c = s2_mode ? f_loa_c : f_exact_c;

  // Pipeline registers; data only loads when a valid transaction moves in
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v      <= 1'b0;
      s1_p1     <= '0;
      s1_p2     <= '0;
      s1_p3     <= '0;
      s1_p4     <= '0;
      s1_mode   <= 1'b0;
      s1_tag    <= '0;
      s2_v      <= 1'b0;
      s2_x      <= '0;
      s2_op1    <= '0;
      s2_lo     <= '0;
      s2_mode   <= 1'b0;
      s2_tag    <= '0;
      out_valid <= 1'b0;
      out_p     <= '0;
      out_tag   <= '0;
      out_mode  <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      s1_v      <= s1_v_n;
      s2_v      <= s2_v_n;
      out_valid <= s3_v_n;
      occupancy <= 2'(s1_v_n) + 2'(s2_v_n) + 2'(s3_v_n);
      if (in_valid && in_ready) begin
        s1_p1   <= p1_c;
        s1_p2   <= p2_c;
        s1_p3   <= p3_c;
        s1_p4   <= p4_c;
        s1_mode <= in_mode;
        s1_tag  <= in_tag;
      end
      if (s1_v && s1_adv_c) begin
        s2_x    <= x_c;
        s2_op1  <= {s1_p1, s1_p4[2*SPLIT-1:SPLIT]};
        s2_lo   <= s1_p4[SPLIT-1:0];
        s2_mode <= s1_mode;
        s2_tag  <= s1_tag;
      end
      if (s2_v && s2_adv_c) begin
        out_p    <= {f_c, s2_lo};
        out_tag  <= s2_tag;
        out_mode <= s2_mode;
      end
    end
  end

endmodule

// File: tb/tb_approx_mult_pipe.sv
module tb_approx_mult_pipe;

  localparam int unsigned W  = 16;
  localparam int unsigned S  = 6;
  localparam int unsigned AB = 4;
  localparam int unsigned TW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            in_valid, in_ready, in_mode, out_valid, out_ready, out_mode;
  logic [W-1:0]    in_a, in_b;
  logic [TW-1:0]   in_tag, out_tag;
  logic [2*W-1:0]  out_p;
  logic [1:0]      occupancy;

  logic            v8_in_valid, v8_in_ready, v8_in_mode, v8_out_valid, v8_out_mode;
  logic            v8_out_ready;
  logic [7:0]      v8_a, v8_b;
  logic [3:0]      v8_in_tag, v8_out_tag;
  logic [15:0]     v8_out_p;
  logic [1:0]      v8_occ;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [31:0] p;
    logic [3:0]  tag;
    logic        mode;
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  approx_mult_pipe #(.WIDTH(W), .SPLIT(S), .APPROX_BITS(AB), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
    .out_tag(out_tag), .out_mode(out_mode), .occupancy(occupancy)
  );

  approx_mult_pipe #(.WIDTH(8), .SPLIT(3), .APPROX_BITS(0), .TAG_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8_in_valid), .in_ready(v8_in_ready),
    .in_a(v8_a), .in_b(v8_b), .in_mode(v8_in_mode), .in_tag(v8_in_tag),
    .out_valid(v8_out_valid), .out_ready(v8_out_ready), .out_p(v8_out_p),
    .out_tag(v8_out_tag), .out_mode(v8_out_mode), .occupancy(v8_occ)
  );

  // Arithmetic LOA adder: OR below k, carry in from the AND of bit k-1
  function automatic longint unsigned loa(longint unsigned a, longint unsigned b, int unsigned k);
    longint unsigned low, c;
    if (k == 0) return a + b;
    low = (a | b) & ((64'd1 << k) - 1);
    c   = (a >> (k - 1)) & (b >> (k - 1)) & 64'd1;
    return (((a >> k) + (b >> k) + c) << k) | low;
  endfunction

  // Reference product for the default configuration
  function automatic logic [31:0] model_p(logic [15:0] a, logic [15:0] b, logic mode);
    longint unsigned ah, al, bh, bl, lmask, x, op1, f;
    int unsigned k;
    k     = mode ? AB : 0;
    lmask = (64'd1 << S) - 1;
    ah = longint'(a) >> S;  al = longint'(a) & lmask;
    bh = longint'(b) >> S;  bl = longint'(b) & lmask;
    x   = loa(ah * bl, al * bh, k);
    op1 = ((ah * bh) << S) | ((al * bl) >> S);
    f   = loa(op1, x, k) & ((64'd1 << (2*W - S)) - 1);
    return 32'((f << S) | ((al * bl) & lmask));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    v8_in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    out_ready = 1'b0;
    tick();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (occupancy !== 2'd0) $display("FAIL reset_occupancy got %0d want 0", occupancy); else pass_cnt++;
    total_cnt++; if (out_p !== 32'd0) $display("FAIL reset_out_p got %h want 0", out_p); else pass_cnt++;
    total_cnt++; if (out_tag !== 4'd0) $display("FAIL reset_out_tag got %h want 0", out_tag); else pass_cnt++;
    total_cnt++; if (out_mode !== 1'b0) $display("FAIL reset_out_mode got %0b want 0", out_mode); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", in_ready); else pass_cnt++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_exact_corner();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'hFFFF; in_mode = 1'b0; in_tag = 4'd5;
    for (int e = 1; e <= 3; e++) begin
      tick();
      in_valid = 1'b0;
      if (e < 3) begin
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL corner_early_valid edge %0d got %0b want 0", e, out_valid); else pass_cnt++;
      end
    end
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL corner_valid got %0b want 1", out_valid); else pass_cnt++;
    total_cnt++; if (out_p !== 32'hFFFE0001) $display("FAIL corner_p got %h want fffe0001", out_p); else pass_cnt++;
    total_cnt++; if (out_tag !== 4'd5) $display("FAIL corner_tag got %0d want 5", out_tag); else pass_cnt++;
    tick();
  endtask

  task automatic test_approx_known();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 16'h007F; in_b = 16'h007F; in_mode = 1'b1; in_tag = 4'd9;
    tick();
    in_mode = 1'b0; in_tag = 4'd3;
    tick();
    in_valid = 1'b0;
    tick();
    total_cnt++; if (out_valid !== 1'b1 || out_p !== 32'h00003FC1 || out_mode !== 1'b1 || out_tag !== 4'd9)
      $display("FAIL approx_7f got v=%0b p=%h m=%0b t=%0d want v=1 p=00003fc1 m=1 t=9", out_valid, out_p, out_mode, out_tag);
    else pass_cnt++;
    tick();
    total_cnt++; if (out_valid !== 1'b1 || out_p !== 32'h00003F01 || out_mode !== 1'b0 || out_tag !== 4'd3)
      $display("FAIL exact_7f got v=%0b p=%h m=%0b t=%0d want v=1 p=00003f01 m=0 t=3", out_valid, out_p, out_mode, out_tag);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    exp_t q[$];
    exp_t e;
    int sent = 0, got = 0, cyc = 0, first = -1, last = -1;
    do_reset();
    out_ready = 1'b1;
    while (got < 200 && cyc < 600) begin
      if (out_valid) begin
        total_cnt++;
        if (q.size() == 0) $display("FAIL b2b_spurious got p=%h want no output", out_p);
        else begin
          e = q.pop_front();
          if (out_p !== e.p || out_tag !== e.tag || out_mode !== e.mode)
            $display("FAIL b2b_result #%0d got p=%h t=%0d m=%0b want p=%h t=%0d m=%0b", got, out_p, out_tag, out_mode, e.p, e.tag, e.mode);
          else pass_cnt++;
          if (e.mode == 1'b0) begin
            total_cnt++;
            if (out_p !== 32'(e.a) * 32'(e.b)) $display("FAIL b2b_exact #%0d got %h want %h", got, out_p, 32'(e.a) * 32'(e.b));
            else pass_cnt++;
          end
          got++;
          if (first < 0) first = cyc;
          last = cyc;
        end
      end
      if (sent < 200) begin
        in_valid = 1'b1;
        in_a = 16'($urandom); in_b = 16'($urandom);
        in_mode = 1'($urandom); in_tag = 4'($urandom);
      end else in_valid = 1'b0;
      if (in_valid && in_ready) begin
        e.a = in_a; e.b = in_b; e.mode = in_mode; e.tag = in_tag;
        e.p = model_p(in_a, in_b, in_mode);
        q.push_back(e);
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    total_cnt++; if (got !== 200) $display("FAIL b2b_count got %0d want 200", got); else pass_cnt++;
    total_cnt++; if (last - first !== 199) $display("FAIL b2b_throughput got span %0d want 199", last - first); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    exp_t q[$];
    exp_t e, held;
    int got = 0, acc = 0;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_a = 16'($urandom); in_b = 16'($urandom);
      in_mode = 1'(i); in_tag = 4'(i + 1);
      if (i == 3) begin
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_4th got %0b want 0", in_ready); else pass_cnt++;
      end
      if (in_ready) begin
        e.a = in_a; e.b = in_b; e.mode = in_mode; e.tag = in_tag;
        e.p = model_p(in_a, in_b, in_mode);
        q.push_back(e);
        acc++;
      end
      if (i < 3) tick();
    end
    total_cnt++; if (acc !== 3) $display("FAIL bp_accepted got %0d want 3", acc); else pass_cnt++;
    held = q[0];
    for (int h = 0; h < 3; h++) begin
      total_cnt++;
      if (occupancy !== 2'd3 || out_valid !== 1'b1 || out_p !== held.p || out_tag !== held.tag || out_mode !== held.mode)
        $display("FAIL bp_hold cycle %0d got occ=%0d v=%0b p=%h t=%0d want occ=3 v=1 p=%h t=%0d", h, occupancy, out_valid, out_p, out_tag, held.p, held.tag);
      else pass_cnt++;
      tick();
    end
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_held got %0b want 0", in_ready); else pass_cnt++;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && got < 4; c++) begin
      if (out_valid) begin
        total_cnt++;
        if (q.size() == 0) $display("FAIL bp_extra got p=%h want no output", out_p);
        else begin
          e = q.pop_front();
          if (out_p !== e.p || out_tag !== e.tag) $display("FAIL bp_result #%0d got p=%h t=%0d want p=%h t=%0d", got, out_p, out_tag, e.p, e.tag);
          else pass_cnt++;
          got++;
        end
      end
      if (in_valid && in_ready) begin
        e.a = in_a; e.b = in_b; e.mode = in_mode; e.tag = in_tag;
        e.p = model_p(in_a, in_b, in_mode);
        q.push_back(e);
        tick();
        in_valid = 1'b0;
      end else tick();
    end
    total_cnt++; if (got !== 4) $display("FAIL bp_count got %0d want 4", got); else pass_cnt++;
    tick();
    total_cnt++; if (out_valid !== 1'b0 || occupancy !== 2'd0) $display("FAIL bp_drained got v=%0b occ=%0d want v=0 occ=0", out_valid, occupancy); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] want;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_a = 16'($urandom); in_b = 16'($urandom); in_mode = 1'b0; in_tag = 4'(i);
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total_cnt++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_p !== 32'd0)
      $display("FAIL midrst_state got v=%0b occ=%0d p=%h want v=0 occ=0 p=0", out_valid, occupancy, out_p);
    else pass_cnt++;
    in_valid = 1'b1; in_a = 16'h1234; in_b = 16'hABCD; in_mode = 1'b1; in_tag = 4'd7;
    want = model_p(16'h1234, 16'hABCD, 1'b1);
    for (int e = 1; e <= 3; e++) begin
      tick();
      in_valid = 1'b0;
      if (e < 3) begin
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL midrst_early edge %0d got %0b want 0", e, out_valid); else pass_cnt++;
      end
    end
    total_cnt++; if (out_valid !== 1'b1 || out_p !== want || out_tag !== 4'd7)
      $display("FAIL midrst_result got v=%0b p=%h t=%0d want v=1 p=%h t=7", out_valid, out_p, out_tag, want);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_sweep8();
    logic [15:0] q[$];
    logic [15:0] w;
    int sent = 0, got = 0, cyc = 0;
    do_reset();
    v8_out_ready = 1'b1;
    while (got < 65536 && cyc < 66000) begin
      if (v8_out_valid) begin
        total_cnt++;
        if (q.size() == 0) $display("FAIL sweep_spurious got %h want no output", v8_out_p);
        else begin
          w = q.pop_front();
          if (v8_out_p !== w) $display("FAIL sweep_p #%0d got %h want %h", got, v8_out_p, w);
          else pass_cnt++;
          got++;
        end
      end
      if (sent < 65536) begin
        v8_in_valid = 1'b1;
        v8_a = 8'(sent >> 8); v8_b = 8'(sent);
        v8_in_mode = 1'($urandom); v8_in_tag = 4'($urandom);
      end else v8_in_valid = 1'b0;
      if (v8_in_valid && v8_in_ready) begin
        q.push_back(16'(v8_a) * 16'(v8_b));
        sent++;
      end
      tick();
      cyc++;
    end
    v8_in_valid = 1'b0;
    total_cnt++; if (got !== 65536) $display("FAIL sweep_count got %0d want 65536", got); else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = 1'b0; in_tag = '0; out_ready = 1'b1;
    v8_in_valid = 1'b0; v8_a = '0; v8_b = '0; v8_in_mode = 1'b0; v8_in_tag = '0; v8_out_ready = 1'b1;
    test_reset();
    test_exact_corner();
    test_approx_known();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_sweep8();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
